icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/icache.sv | 104 ++++++++++
 tb/tb_icache.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the instruction-cache state and entry types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Tag storage is sized for the smallest legal cache (2 sets -> 29 tag bits),
  // rounded up to 30 so every set count stores its tag zero-extended.
  localparam int ICACHE_TAG_W = 30;

  typedef enum logic {
    COMPARE = 1'b0,
    FETCH   = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_entry_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-set instruction cache with a blocking
// single-outstanding miss. Hits are combinational; a miss latches the PC and
// holds the memory request until the memory drops iwait.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int IDX_W = $clog2(SETS);

  icache_entry_t r_ents [SETS];
  icache_state_t r_state;
  icache_state_t w_next_state;
  word_t         r_miss_addr;
  word_t         r_hit_count;
  word_t         r_miss_count;

  logic [IDX_W-1:0]        w_idx;
  logic [ICACHE_TAG_W-1:0] w_tag;
  logic [IDX_W-1:0]        w_miss_idx;
  logic [ICACHE_TAG_W-1:0] w_miss_tag;
  logic                    w_lookup_hit;
  logic                    w_miss;
  logic                    w_fill;

  assign w_idx      = imemaddr[IDX_W+1:2];
  assign w_tag      = ICACHE_TAG_W'(imemaddr >> (IDX_W + 2));
  assign w_miss_idx = r_miss_addr[IDX_W+1:2];
  assign w_miss_tag = ICACHE_TAG_W'(r_miss_addr >> (IDX_W + 2));

  assign w_lookup_hit = imemREN && r_ents[w_idx].valid && (r_ents[w_idx].tag == w_tag);
  assign w_miss       = (r_state == COMPARE) && imemREN && !w_lookup_hit;

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Next-state and output decode; FETCH ignores the datapath side entirely.
  always_comb begin
    w_next_state = r_state;
    ihit         = 1'b0;
    imemload     = '0;
    iREN         = 1'b0;
    iaddr        = '0;
    w_fill       = 1'b0;
    if (r_state == COMPARE) begin
      ihit = w_lookup_hit;
      if (w_lookup_hit) begin
        imemload = r_ents[w_idx].data;
      end
      if (w_miss) begin
        w_next_state = FETCH;
      end
    end else begin
      iREN  = 1'b1;
      iaddr = r_miss_addr;
      if (!iwait) begin
        w_fill       = 1'b1;
        w_next_state = COMPARE;
      end
    end
  end

  // State, miss address, array fill and statistics; reset discards any fill in flight.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_state      <= COMPARE;
      r_miss_addr  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      for (int i = 0; i < SETS; i++) begin
        r_ents[i] <= '0;
      end
    end else begin
      r_state <= w_next_state;
      if (w_miss) begin
        r_miss_addr <= imemaddr;
      end
      if (w_fill) begin
        r_ents[w_miss_idx].valid <= 1'b1;
        r_ents[w_miss_idx].tag   <= w_miss_tag;
        r_ents[w_miss_idx].data  <= iload;
        r_miss_count             <= r_miss_count + 32'd1;
      end
      if (ihit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (SETS=16) with a hand-driven memory side.
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  word_t hit_count;
  word_t miss_count;

  int checks = 0;
  int errors = 0;

  icache #(.SETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after an input change before sampling.
  task automatic settle();
    #1;
  endtask

  // Complete a miss on addr: one COMPARE cycle, waits busy cycles, then data.
  task automatic do_miss(input word_t addr, input word_t data, input int waits);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    step();
    for (int i = 0; i < waits; i++) step();
    iwait = 1'b0; iload = data;
    step();
    iwait = 1'b1; iload = '0;
    settle();
  endtask

  task automatic test_reset();
    nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; iload = '0;
    step(); step();
    settle();
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rst_ihit: got %b want 0", ihit); end
    checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL rst_imemload: got %h want 0", imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_iREN: got %b want 0", iREN); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL rst_iaddr: got %h want 0", iaddr); end
    checks++; if (hit_count !== 32'h0) begin errors++; $display("FAIL rst_hit_count: got %0d want 0", hit_count); end
    checks++; if (miss_count !== 32'h0) begin errors++; $display("FAIL rst_miss_count: got %0d want 0", miss_count); end
    imemREN = 1'b0;
    step();
    nRST = 1'b0;
    settle();
    checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin errors++; $display("FAIL post_rst_mem: got iREN=%b iaddr=%h want 0/0", iREN, iaddr); end
  endtask

  task automatic test_cold_miss();
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
    settle();
    checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL cold_compare: got ihit=%b iREN=%b want 0/0", ihit, iREN); end
    step();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin iwait = 1'b0; iload = 32'h8C220004; end
      settle();
      checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin errors++; $display("FAIL cold_fetch%0d: got iREN=%b iaddr=%h want 1/00000040", c, iREN, iaddr); end
      checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cold_fetch_ihit%0d: got %b want 0", c, ihit); end
      step();
    end
    iwait = 1'b1; iload = '0;
    settle();
    checks++; if (ihit !== 1'b1 || imemload !== 32'h8C220004) begin errors++; $display("FAIL cold_done: got ihit=%b data=%h want 1/8c220004", ihit, imemload); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL cold_miss_count: got %0d want 1", miss_count); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL cold_done_iREN: got %b want 0", iREN); end
  endtask

  task automatic test_hit();
    for (int c = 0; c < 4; c++) begin
      imemREN = 1'b1; imemaddr = 32'h40;
      settle();
      checks++; if (ihit !== 1'b1 || imemload !== 32'h8C220004 || iREN !== 1'b0) begin
        errors++; $display("FAIL hit%0d: got ihit=%b data=%h iREN=%b want 1/8c220004/0", c, ihit, imemload, iREN); end
      step();
    end
    checks++; if (hit_count !== 32'd4) begin errors++; $display("FAIL hit_count: got %0d want 4", hit_count); end
  endtask

  task automatic test_idle();
    imemREN = 1'b0; imemaddr = 32'h40;
    settle();
    checks++; if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
      errors++; $display("FAIL idle: got ihit=%b data=%h iREN=%b want 0/0/0", ihit, imemload, iREN); end
    step(); step();
    checks++; if (hit_count !== 32'd4) begin errors++; $display("FAIL idle_hit_count: got %0d want 4", hit_count); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL idle_miss_count: got %0d want 1", miss_count); end
  endtask

  task automatic test_conflict();
    do_miss(32'h440, 32'h11111111, 0);
    checks++; if (ihit !== 1'b1 || imemload !== 32'h11111111) begin errors++; $display("FAIL conf_440: got ihit=%b data=%h want 1/11111111", ihit, imemload); end
    checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL conf_mc2: got %0d want 2", miss_count); end
    imemaddr = 32'h40;
    settle();
    checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++; $display("FAIL conf_40_evicted: got ihit=%b data=%h want 0/0", ihit, imemload); end
    do_miss(32'h40, 32'h8C220004, 1);
    checks++; if (ihit !== 1'b1 || imemload !== 32'h8C220004) begin errors++; $display("FAIL conf_40_refill: got ihit=%b data=%h want 1/8c220004", ihit, imemload); end
    checks++; if (miss_count !== 32'd3) begin errors++; $display("FAIL conf_mc3: got %0d want 3", miss_count); end
  endtask

  task automatic test_redirect();
    imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
    step();
    imemaddr = 32'h100;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin iwait = 1'b0; iload = 32'hAAAA0080; end
      settle();
      checks++; if (iREN !== 1'b1 || iaddr !== 32'h80 || ihit !== 1'b0) begin
        errors++; $display("FAIL redir_fetch%0d: got iREN=%b iaddr=%h ihit=%b want 1/00000080/0", c, iREN, iaddr, ihit); end
      step();
    end
    iwait = 1'b1; iload = '0;
    imemaddr = 32'h80;
    settle();
    checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0080) begin errors++; $display("FAIL redir_80_filled: got ihit=%b data=%h want 1/aaaa0080", ihit, imemload); end
    checks++; if (miss_count !== 32'd4) begin errors++; $display("FAIL redir_mc4: got %0d want 4", miss_count); end
    imemaddr = 32'h100;
    settle();
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redir_100_miss: got %b want 0", ihit); end
    step();
    iwait = 1'b0; iload = 32'hBBBB0100;
    settle();
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin errors++; $display("FAIL redir_100_fetch: got iREN=%b iaddr=%h want 1/00000100", iREN, iaddr); end
    step();
    iwait = 1'b1; iload = '0;
    settle();
    checks++; if (ihit !== 1'b1 || imemload !== 32'hBBBB0100) begin errors++; $display("FAIL redir_100_hit: got ihit=%b data=%h want 1/bbbb0100", ihit, imemload); end
    checks++; if (miss_count !== 32'd5) begin errors++; $display("FAIL redir_mc5: got %0d want 5", miss_count); end
    imemREN = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_fetch();
    imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1;
    step();
    settle();
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h200) begin errors++; $display("FAIL rmf_fetch: got iREN=%b iaddr=%h want 1/00000200", iREN, iaddr); end
    nRST = 1'b1;
    step();
    nRST = 1'b0;
    settle();
    checks++; if (iREN !== 1'b0 || iaddr !== 32'h0) begin errors++; $display("FAIL rmf_iREN: got iREN=%b iaddr=%h want 0/0", iREN, iaddr); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++; $display("FAIL rmf_counters: got hit=%0d miss=%0d want 0/0", hit_count, miss_count); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmf_200_miss: got %b want 0", ihit); end
    imemaddr = 32'h100;
    settle();
    checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++; $display("FAIL rmf_100_cleared: got ihit=%b data=%h want 0/0", ihit, imemload); end
    imemREN = 1'b0;
    step();
  endtask

  initial begin
    nRST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    #1;
    test_reset();
    test_cold_miss();
    test_hit();
    test_idle();
    test_conflict();
    test_redirect();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
